// File: rtl/snake_pkg.sv
// Shared types for the screen multiplexer.
//   screen_t : which screen pipeline is selected
//   RGB_B    : pixel colour width (three 4-bit channels)
//   vga_t    : packed copy of one timing bus, used inside pipeline registers
package snake_pkg;

   localparam int RGB_B = 12;
   localparam int CNT_W = 11;

   typedef enum logic [1:0] {
      SCR_MENU = 2'd0,
      SCR_GAME = 2'd1,
      SCR_LOSE = 2'd2,
      SCR_WIN  = 2'd3
   } screen_t;

   typedef struct packed {
      logic [CNT_W-1:0] hcount;
      logic [CNT_W-1:0] vcount;
      logic             hblnk;
      logic             vblnk;
      logic             hsync;
      logic             vsync;
   } vga_t;

endpackage

// File: rtl/vga_if.sv
// VGA timing bus: counters, blanking and sync strobes.
//   modport in  : consumer side
//   modport out : producer side
interface vga_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hblnk;
   logic        vblnk;
   logic        hsync;
   logic        vsync;

   modport in  (input  hcount, vcount, hblnk, vblnk, hsync, vsync);
   modport out (output hcount, vcount, hblnk, vblnk, hsync, vsync);
endinterface

// File: rtl/rgb_scale.sv
// Combinational brightness scaler for one 12-bit pixel.
//   rgb    : input pixel, three 4-bit channels
//   level  : 0..16; 16 passes the pixel unchanged
//   scaled : each channel = (channel*level)>>4, or unchanged at level 16
module rgb_scale
   import snake_pkg::*;
(
   input  logic [RGB_B-1:0] rgb,
   input  logic [4:0]       level,
   output logic [RGB_B-1:0] scaled
);

   for (genvar c = 0; c < 3; c++) begin : g_ch
      logic [7:0] prod;
      // 15*15 = 225 fits in 8 bits; level 16 is handled by the bypass
      assign prod = {4'd0, rgb[c*4 +: 4]} * {4'd0, level[3:0]};
      assign scaled[c*4 +: 4] = level[4] ? rgb[c*4 +: 4] : 4'(prod >> 4);
   end

endmodule

// File: rtl/screen_mux.sv
// Selects one of four screen pipelines and fades in a new screen after a
// switch. Switches only take effect on a frame boundary (rising edge of
// the game pipeline's vblnk). Two-cycle latency for timing and colour.
//   clk, rst              : pixel clock, synchronous active-high reset
//   screen_sel            : requested screen
//   vga_* / rgb_*         : timing bus and colour of each pipeline
//   vga_out / rgb_o       : selected timing and faded colour
//   busy                  : high while a switch or fade is in progress
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_SHOW | steady display of active screen at full brightness
// ST_WAIT | new screen requested, waiting for the next frame boundary
// ST_FADE | new screen is active, brightness ramping 0 -> 16
module screen_mux
   import snake_pkg::*;
#(
   parameter int               FADE_FRAMES = 2,
   parameter logic [RGB_B-1:0] BLANK_COLOR = 12'h000
) (
   input  logic             clk,
   input  logic             rst,
   input  screen_t          screen_sel,
   vga_if.in                vga_menu,
   vga_if.in                vga_game,
   vga_if.in                vga_lose,
   vga_if.in                vga_win,
   input  logic [RGB_B-1:0] rgb_menu,
   input  logic [RGB_B-1:0] rgb_game,
   input  logic [RGB_B-1:0] rgb_lose,
   input  logic [RGB_B-1:0] rgb_win,
   vga_if.out               vga_out,
   output logic [RGB_B-1:0] rgb_o,
   output logic             busy
);

   typedef enum logic [1:0] {ST_SHOW, ST_WAIT, ST_FADE} state_t;

   localparam logic [3:0] FRAME_LAST = 4'(FADE_FRAMES - 1);

   state_t           state_q, state_d;
   screen_t          active_q, active_d;
   screen_t          pending_q, pending_d;
   logic [4:0]       level_q, level_d;
   logic [3:0]       frame_q, frame_d;
   logic             game_vblnk_q;
   logic             frame_edge;

   vga_t             src_vga;
   logic [RGB_B-1:0] src_rgb;
   vga_t             s1_vga_q, s2_vga_q;
   logic [RGB_B-1:0] s1_rgb_q, rgb_q, rgb_d, scaled;

   assign frame_edge = vga_game.vblnk & ~game_vblnk_q;

   always_comb begin
      src_vga = '0;
      src_rgb = '0;
      case (active_q)
         SCR_MENU: begin
            src_vga = {vga_menu.hcount, vga_menu.vcount, vga_menu.hblnk,
                       vga_menu.vblnk, vga_menu.hsync, vga_menu.vsync};
            src_rgb = rgb_menu;
         end
         SCR_GAME: begin
            src_vga = {vga_game.hcount, vga_game.vcount, vga_game.hblnk,
                       vga_game.vblnk, vga_game.hsync, vga_game.vsync};
            src_rgb = rgb_game;
         end
         SCR_LOSE: begin
            src_vga = {vga_lose.hcount, vga_lose.vcount, vga_lose.hblnk,
                       vga_lose.vblnk, vga_lose.hsync, vga_lose.vsync};
            src_rgb = rgb_lose;
         end
         default: begin
            src_vga = {vga_win.hcount, vga_win.vcount, vga_win.hblnk,
                       vga_win.vblnk, vga_win.hsync, vga_win.vsync};
            src_rgb = rgb_win;
         end
      endcase
   end

   always_comb begin
      state_d   = state_q;
      active_d  = active_q;
      pending_d = pending_q;
      level_d   = level_q;
      frame_d   = frame_q;
      case (state_q)
         ST_SHOW: begin
            level_d = 5'd16;
            if (screen_sel != active_q) begin
               pending_d = screen_sel;
               state_d   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // level is held so a re-select during a fade keeps its brightness
            pending_d = screen_sel;
            if (frame_edge) begin
               active_d = pending_q;
               level_d  = 5'd0;
               frame_d  = 4'd0;
               state_d  = ST_FADE;
            end else if (screen_sel == active_q) begin
               level_d = 5'd16;
               state_d = ST_SHOW;
            end
         end
         ST_FADE: begin
            if (screen_sel != active_q) begin
               pending_d = screen_sel;
               state_d   = ST_WAIT;
            end else if (frame_edge) begin
               if (frame_q == FRAME_LAST) begin
                  frame_d = 4'd0;
                  if (level_q == 5'd15) begin
                     level_d = 5'd16;
                     state_d = ST_SHOW;
                  end else begin
                     level_d = level_q + 5'd1;
                  end
               end else begin
                  frame_d = frame_q + 4'd1;
               end
            end
         end
         default: state_d = ST_SHOW;
      endcase
   end

   rgb_scale u_scale (
      .rgb    (s1_rgb_q),
      .level  (level_q),
      .scaled (scaled)
   );

   always_comb begin
      rgb_d = scaled;
      if (s1_vga_q.hblnk || s1_vga_q.vblnk || level_q == 5'd0) rgb_d = BLANK_COLOR;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_SHOW;
         active_q     <= SCR_MENU;
         pending_q    <= SCR_MENU;
         level_q      <= 5'd16;
         frame_q      <= 4'd0;
         game_vblnk_q <= 1'b0;
         s1_vga_q     <= '0;
         s1_rgb_q     <= '0;
         s2_vga_q     <= '0;
         rgb_q        <= '0;
      end else begin
         state_q      <= state_d;
         active_q     <= active_d;
         pending_q    <= pending_d;
         level_q      <= level_d;
         frame_q      <= frame_d;
         game_vblnk_q <= vga_game.vblnk;
         s1_vga_q     <= src_vga;
         s1_rgb_q     <= src_rgb;
         s2_vga_q     <= s1_vga_q;
         rgb_q        <= rgb_d;
      end
   end

   assign vga_out.hcount = s2_vga_q.hcount;
   assign vga_out.vcount = s2_vga_q.vcount;
   assign vga_out.hblnk  = s2_vga_q.hblnk;
   assign vga_out.vblnk  = s2_vga_q.vblnk;
   assign vga_out.hsync  = s2_vga_q.hsync;
   assign vga_out.vsync  = s2_vga_q.vsync;
   assign rgb_o          = rgb_q;
   assign busy           = (state_q != ST_SHOW);

endmodule

// File: tb/tb_screen_mux.sv
// Directed bench for screen_mux on a tiny 16x8 raster (12x6 visible).
module tb_screen_mux;
   import snake_pkg::*;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   screen_t     screen_sel;
   logic [11:0] rgb_menu, rgb_game, rgb_lose, rgb_win, rgb_o;
   logic        busy;

   vga_if vif_menu ();
   vga_if vif_game ();
   vga_if vif_lose ();
   vga_if vif_win  ();
   vga_if vif_out  ();

   screen_mux #(.FADE_FRAMES(2), .BLANK_COLOR(12'h000)) dut (
      .clk        (clk),
      .rst        (rst),
      .screen_sel (screen_sel),
      .vga_menu   (vif_menu),
      .vga_game   (vif_game),
      .vga_lose   (vif_lose),
      .vga_win    (vif_win),
      .rgb_menu   (rgb_menu),
      .rgb_game   (rgb_game),
      .rgb_lose   (rgb_lose),
      .rgb_win    (rgb_win),
      .vga_out    (vif_out),
      .rgb_o      (rgb_o),
      .busy       (busy)
   );

   int n_checks = 0;
   int n_errors = 0;
   int h = 0, v = 0, h1 = 0, h2 = 0, v1 = 0, v2 = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic drive_one(output logic [10:0] hc, output logic [10:0] vc,
                            output logic hb, output logic vb,
                            output logic hs, output logic vs);
      hc = 11'(h);
      vc = 11'(v);
      hb = (h >= 12);
      vb = (v >= 6);
      hs = (h == 13 || h == 14);
      vs = (v == 7);
   endtask

   task automatic drive_timing();
      drive_one(vif_menu.hcount, vif_menu.vcount, vif_menu.hblnk, vif_menu.vblnk,
                vif_menu.hsync, vif_menu.vsync);
      drive_one(vif_game.hcount, vif_game.vcount, vif_game.hblnk, vif_game.vblnk,
                vif_game.hsync, vif_game.vsync);
      drive_one(vif_lose.hcount, vif_lose.vcount, vif_lose.hblnk, vif_lose.vblnk,
                vif_lose.hsync, vif_lose.vsync);
      drive_one(vif_win.hcount, vif_win.vcount, vif_win.hblnk, vif_win.vblnk,
                vif_win.hsync, vif_win.vsync);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      h2 = h1; h1 = h;
      v2 = v1; v1 = v;
      if (h == 15) begin
         h = 0;
         v = (v == 7) ? 0 : v + 1;
      end else begin
         h = h + 1;
      end
      drive_timing();
   endtask

   task automatic goto(input int th, input int tv);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!(h == th && v == tv) && n < 400);
      if (!(h == th && v == tv)) check("goto_timeout", 32'(h * 256 + v), 32'(th * 256 + tv));
   endtask

   initial begin
      rst        = 1'b1;
      screen_sel = SCR_MENU;
      rgb_menu   = 12'h123;
      rgb_game   = 12'h456;
      rgb_lose   = 12'hF84;
      rgb_win    = 12'h0F0;
      drive_timing();
      repeat (3) tick();
      @(negedge clk);
      check("rst_rgb",    32'(rgb_o), 32'h0);
      check("rst_busy",   32'(busy), 32'h0);
      check("rst_hcount", 32'(vif_out.hcount), 32'h0);
      rst = 1'b0;

      // static pass-through and two-cycle latency
      goto(4, 1);
      @(negedge clk);
      check("static_rgb",    32'(rgb_o), 32'h123);
      check("static_hcount", 32'(vif_out.hcount), 32'(h2));
      check("static_vcount", 32'(vif_out.vcount), 32'(v2));
      rgb_menu = 12'hABC;
      tick();
      @(negedge clk);
      check("lat_1cyc", 32'(rgb_o), 32'h123);
      tick();
      @(negedge clk);
      check("lat_2cyc", 32'(rgb_o), 32'hABC);
      check("lat_hcount", 32'(vif_out.hcount), 32'(h2));

      // switch to lose mid-frame
      goto(8, 2);
      screen_sel = SCR_LOSE;
      tick();
      @(negedge clk);
      check("sw_busy", 32'(busy), 32'h1);
      goto(4, 5);
      @(negedge clk);
      check("sw_menu_holds", 32'(rgb_o), 32'hABC);
      goto(6, 0);
      @(negedge clk);
      check("sw_level0", 32'(rgb_o), 32'h000);
      check("sw_level0_busy", 32'(busy), 32'h1);
      for (int b = 1; b <= 32; b++) begin
         goto(6, 0);
         @(negedge clk);
         case (b)
            1:  check("fade_b1", 32'(rgb_o), 32'h000);
            4:  check("fade_lvl2", 32'(rgb_o), 32'h110);
            16: begin
               check("fade_lvl8", 32'(rgb_o), 32'h742);
               check("fade_lvl8_busy", 32'(busy), 32'h1);
            end
            31: begin
               check("fade_lvl15", 32'(rgb_o), 32'hE73);
               check("fade_lvl15_busy", 32'(busy), 32'h1);
            end
            32: begin
               check("fade_done", 32'(rgb_o), 32'hF84);
               check("fade_done_busy", 32'(busy), 32'h0);
            end
            default: ;
         endcase
      end

      // blanking colour
      goto(14, 1);
      @(negedge clk);
      check("hblank_rgb", 32'(rgb_o), 32'h000);
      check("hblank_flag", 32'(vif_out.hblnk), 32'h1);

      // bounce within one frame
      goto(2, 2);
      screen_sel = SCR_GAME;
      tick();
      @(negedge clk);
      check("bounce_busy", 32'(busy), 32'h1);
      tick();
      screen_sel = SCR_LOSE;
      tick();
      @(negedge clk);
      check("bounce_idle", 32'(busy), 32'h0);
      goto(6, 0);
      @(negedge clk);
      check("bounce_rgb", 32'(rgb_o), 32'hF84);
      check("bounce_busy_after", 32'(busy), 32'h0);

      // re-select during fade
      goto(8, 1);
      screen_sel = SCR_MENU;
      goto(6, 0);
      @(negedge clk);
      check("resel_lvl0", 32'(rgb_o), 32'h000);
      for (int b = 1; b <= 10; b++) goto(6, 0);
      @(negedge clk);
      check("resel_lvl5", 32'(rgb_o), 32'h333);
      goto(8, 0);
      screen_sel = SCR_WIN;
      tick();
      @(negedge clk);
      check("resel_busy", 32'(busy), 32'h1);
      goto(4, 3);
      @(negedge clk);
      check("resel_hold", 32'(rgb_o), 32'h333);
      goto(6, 0);
      @(negedge clk);
      check("resel_win_lvl0", 32'(rgb_o), 32'h000);
      for (int b = 1; b <= 4; b++) goto(6, 0);
      @(negedge clk);
      check("resel_win_lvl2", 32'(rgb_o), 32'h010);

      // reset in the middle of a fade
      goto(4, 1);
      rst = 1'b1;
      tick();
      @(negedge clk);
      check("midrst_rgb",  32'(rgb_o), 32'h0);
      check("midrst_busy", 32'(busy), 32'h0);
      check("midrst_hcount", 32'(vif_out.hcount), 32'h0);
      rst        = 1'b0;
      screen_sel = SCR_MENU;
      tick();
      tick();
      @(negedge clk);
      check("postrst_rgb",  32'(rgb_o), 32'hABC);
      check("postrst_busy", 32'(busy), 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
